hazard_ctrl: RTL and testbench

//  Hazard controller for the 5-stage pipeline. Computes the execute-stage operand forwarding selects.

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_ctrl_fwd_sel.sv | 28 ++
 rtl/hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// rd-source codes, controller state and the bundled stall/flush controls.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   localparam logic [1:0] RD_SRC_ALU = 2'b00;
   localparam logic [1:0] RD_SRC_MEM = 2'b01;
   localparam logic [1:0] RD_SRC_PC  = 2'b10;
   localparam logic [1:0] RD_SRC_IMM = 2'b11;

   typedef enum logic [1:0] {
      HZ_IDLE     = 2'b00,
      HZ_MEM_WAIT = 2'b01,
      HZ_MEM_ERR  = 2'b10
   } hz_state_e;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic flush_d;
      logic flush_e;
   } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one execute-stage source register. The memory stage
// holds the younger result, so it wins over writeback.
module hazard_ctrl_fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs_e_i,
   input  logic [4:0] rd_m_i,
   input  logic       rd_write_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       rd_write_w_i,
   output logic [1:0] fwd_o
);

   logic hit_m;
   logic hit_w;

   always_comb begin
      hit_m = rd_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i);
      hit_w = rd_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i);
      fwd_o = FWD_NONE;
      if (hit_m) begin
         fwd_o = FWD_MEM;
      end else if (hit_w) begin
         fwd_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and redirect
// handling, data-memory wait freeze with timeout, and stall/flush counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic             rd_write_e,
   input  logic [1:0]       rd_write_src_e,
   input  logic             pc_write_e,
   input  logic [4:0]       rd_m,
   input  logic [4:0]       rd_w,
   input  logic             rd_write_m,
   input  logic             rd_write_w,
   input  logic             mem_req_m,
   input  logic             mem_ready_m,
   output logic [1:0]       forwarding_rs1_e,
   output logic [1:0]       forwarding_rs2_e,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles,
   output hz_state_e        dbg_state_o
);

   localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_e        state_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic             mem_err_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;

   logic [1:0] fwd1;
   logic [1:0] fwd2;
   logic       load_use;
   logic       mem_busy;
   hz_ctrl_t   ctrl;

   hazard_ctrl_fwd_sel u_fwd_rs1 (
      .rs_e_i       (rs1_e),
      .rd_m_i       (rd_m),
      .rd_write_m_i (rd_write_m),
      .rd_w_i       (rd_w),
      .rd_write_w_i (rd_write_w),
      .fwd_o        (fwd1)
   );

   hazard_ctrl_fwd_sel u_fwd_rs2 (
      .rs_e_i       (rs2_e),
      .rd_m_i       (rd_m),
      .rd_write_m_i (rd_write_m),
      .rd_w_i       (rd_w),
      .rd_write_w_i (rd_write_w),
      .fwd_o        (fwd2)
   );

   // A waiting access releases the freeze in the very cycle ready arrives.
   always_comb begin
      load_use = rd_write_e && (rd_write_src_e == RD_SRC_MEM) && (rd_e != 5'd0) &&
                 ((rd_e == rs1_d) || (rd_e == rs2_d));
      mem_busy = ((state_q == HZ_IDLE) && mem_req_m && !mem_ready_m) ||
                 ((state_q == HZ_MEM_WAIT) && !mem_ready_m) ||
                 (state_q == HZ_MEM_ERR);
   end

   always_comb begin
      ctrl = '0;
      if (!rst_n) begin
         ctrl = '0;
      end else if (mem_busy) begin
         ctrl.stall_f = 1'b1;
         ctrl.stall_d = 1'b1;
         ctrl.stall_e = 1'b1;
         ctrl.stall_m = 1'b1;
      end else if (pc_write_e) begin
         ctrl.flush_d = 1'b1;
         ctrl.flush_e = 1'b1;
      end else if (load_use) begin
         ctrl.stall_f = 1'b1;
         ctrl.stall_d = 1'b1;
         ctrl.flush_e = 1'b1;
      end
   end

   assign forwarding_rs1_e = rst_n ? fwd1 : FWD_NONE;
   assign forwarding_rs2_e = rst_n ? fwd2 : FWD_NONE;
   assign stall_f          = ctrl.stall_f;
   assign stall_d          = ctrl.stall_d;
   assign stall_e          = ctrl.stall_e;
   assign stall_m          = ctrl.stall_m;
   assign flush_d          = ctrl.flush_d;
   assign flush_e          = ctrl.flush_e;
   assign mem_err          = mem_err_q;
   assign stall_cycles     = stall_cnt_q;
   assign flush_cycles     = flush_cnt_q;
   assign dbg_state_o      = state_q;

   // wait_cnt_q counts stalled cycles of the current access; the error
   // state is absorbing until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HZ_IDLE;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         case (state_q)
            HZ_IDLE: begin
               if (mem_req_m && !mem_ready_m) begin
                  state_q    <= HZ_MEM_WAIT;
                  wait_cnt_q <= WAIT_W'(1);
               end
            end
            HZ_MEM_WAIT: begin
               if (mem_ready_m) begin
                  state_q    <= HZ_IDLE;
                  wait_cnt_q <= '0;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_q   <= HZ_MEM_ERR;
                  mem_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
               end
            end
            HZ_MEM_ERR: begin
               mem_err_q <= 1'b1;
            end
            default: begin
               state_q    <= HZ_IDLE;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (ctrl.stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ctrl.flush_e && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl with a cycle-level behavioural model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int EW          = 11 + 2 * CNT_W;

  logic             clk;
  logic             rst_n;
  logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic             rd_write_e, pc_write_e, rd_write_m, rd_write_w;
  logic [1:0]       rd_write_src_e;
  logic             mem_req_m, mem_ready_m;
  logic [1:0]       forwarding_rs1_e, forwarding_rs2_e;
  logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;
  hz_state_e        dbg_state;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rs1_d            (rs1_d),
    .rs2_d            (rs2_d),
    .rs1_e            (rs1_e),
    .rs2_e            (rs2_e),
    .rd_e             (rd_e),
    .rd_write_e       (rd_write_e),
    .rd_write_src_e   (rd_write_src_e),
    .pc_write_e       (pc_write_e),
    .rd_m             (rd_m),
    .rd_w             (rd_w),
    .rd_write_m       (rd_write_m),
    .rd_write_w       (rd_write_w),
    .mem_req_m        (mem_req_m),
    .mem_ready_m      (mem_ready_m),
    .forwarding_rs1_e (forwarding_rs1_e),
    .forwarding_rs2_e (forwarding_rs2_e),
    .stall_f          (stall_f),
    .stall_d          (stall_d),
    .stall_e          (stall_e),
    .stall_m          (stall_m),
    .flush_d          (flush_d),
    .flush_e          (flush_e),
    .mem_err          (mem_err),
    .stall_cycles     (stall_cycles),
    .flush_cycles     (flush_cycles),
    .dbg_state_o      (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: number of stalled cycles of the outstanding access
  bit m_err;
  bit m_in_wait;
  int m_wait_n;
  int m_sc;
  int m_fc;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rd_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (rd_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    rd_write_e = 0; rd_write_src_e = 0; pc_write_e = 0;
    rd_write_m = 0; rd_write_w = 0; mem_req_m = 0; mem_ready_m = 0;
  endtask

  // Called at posedge+1 with inputs already applied; predicts this cycle's
  // outputs, then advances the model across the next rising edge.
  task automatic cycle();
    logic [1:0] f1, f2;
    logic sf, sd, se, sm, fd, fe, lu, busy;
    if (!rst_n) begin
      m_err = 0; m_in_wait = 0; m_wait_n = 0; m_sc = 0; m_fc = 0;
    end
    f1 = ref_fwd(rs1_e);
    f2 = ref_fwd(rs2_e);
    lu = rd_write_e && rd_write_src_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    busy = m_err || ((m_in_wait || mem_req_m) && !mem_ready_m);
    {sf, sd, se, sm, fd, fe} = 6'b0;
    if (!rst_n) begin
      f1 = 0; f2 = 0;
    end else if (busy) begin
      {sf, sd, se, sm} = 4'hF;
    end else if (pc_write_e) begin
      {fd, fe} = 2'b11;
    end else if (lu) begin
      sf = 1; sd = 1; fe = 1;
    end
    exp_q.push_back({f1, f2, sf, sd, se, sm, fd, fe, m_err, CNT_W'(m_sc), CNT_W'(m_fc)});
    @(posedge clk);
    if (rst_n) begin
      if (sd && m_sc < CNT_MAX) m_sc++;
      if (fe && m_fc < CNT_MAX) m_fc++;
      if (!m_err) begin
        if (busy) begin
          m_in_wait = 1;
          m_wait_n++;
          if (m_wait_n == MEM_TIMEOUT) m_err = 1;
        end else begin
          m_in_wait = 0;
          m_wait_n  = 0;
        end
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("forwarding_rs1_e", forwarding_rs1_e, e[EW-1 -: 2]);
      check("forwarding_rs2_e", forwarding_rs2_e, e[EW-3 -: 2]);
      check("stall_f", stall_f, e[2*CNT_W+6]);
      check("stall_d", stall_d, e[2*CNT_W+5]);
      check("stall_e", stall_e, e[2*CNT_W+4]);
      check("stall_m", stall_m, e[2*CNT_W+3]);
      check("flush_d", flush_d, e[2*CNT_W+2]);
      check("flush_e", flush_e, e[2*CNT_W+1]);
      check("mem_err", mem_err, e[2*CNT_W]);
      check("stall_cycles", stall_cycles, e[2*CNT_W-1 -: CNT_W]);
      check("flush_cycles", flush_cycles, e[CNT_W-1:0]);
    end
  end

  // stimulus
  initial begin
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    mem_req_m = 1; rs1_e = 3; rd_m = 3; rd_write_m = 1;
    run(3);
    clear_inputs();
    rst_n = 1;
    run(1);

    // forwarding priority, then rd_m = 0
    rd_m = 5; rd_write_m = 1; rd_w = 5; rd_write_w = 1; rs1_e = 5; rs2_e = 5;
    run(1);
    rd_m = 0;
    run(1);
    clear_inputs();

    // single load-use bubble
    rd_e = 7; rd_write_e = 1; rd_write_src_e = 2'b01; rs2_d = 7;
    run(1);
    clear_inputs();
    run(1);

    // redirect beats load-use
    rd_e = 7; rd_write_e = 1; rd_write_src_e = 2'b01; rs1_d = 7; pc_write_e = 1;
    run(1);
    clear_inputs();
    run(1);

    // three-cycle memory wait with branch held behind it
    mem_req_m = 1; mem_ready_m = 0; pc_write_e = 1;
    run(3);
    mem_ready_m = 1;
    run(1);
    mem_req_m = 0; mem_ready_m = 0;
    run(1);
    clear_inputs();
    run(1);

    // timeout into sticky error, then an asynchronous reset pulse
    mem_req_m = 1;
    run(6);
    mem_req_m = 0; mem_ready_m = 1;
    run(2);
    rst_n = 0;
    run(1);
    rst_n = 1; mem_ready_m = 0;
    run(2);

    // reset mid-wait
    mem_req_m = 1;
    run(2);
    rst_n = 0;
    run(1);
    rst_n = 1; mem_req_m = 0;
    run(2);

    // counter saturation: 2^CNT_W + 2 load-use stalls
    rd_e = 9; rd_write_e = 1; rd_write_src_e = 2'b01; rs1_d = 9;
    run((1 << CNT_W) + 2);
    clear_inputs();
    run(1);
    rst_n = 0;
    run(1);
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rs1_d = 5'($urandom_range(0, 3));
      rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3));
      rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3));
      rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      rd_write_e     = 1'($urandom_range(0, 1));
      rd_write_src_e = 2'($urandom_range(0, 3));
      rd_write_m     = 1'($urandom_range(0, 1));
      rd_write_w     = 1'($urandom_range(0, 1));
      pc_write_e     = ($urandom_range(0, 4) == 0);
      mem_req_m      = ($urandom_range(0, 9) < 3);
      mem_ready_m    = 1'($urandom_range(0, 1));
      rst_n          = ($urandom_range(0, 39) != 0);
      cycle();
    end
    rst_n = 1;
    clear_inputs();
    run(1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
